line_raster_engine: RTL

Parametrised successor to the fixed 10-bit line drawer: accepts one line op (two endpoints, color, dash pattern) over an rts/rtr handshake and walks it with Bresenham's algorithm. It emits one {x, y, color} pixel per cycle toward the output FIFO and addressing engine. Compared with the current drawer it adds:
- parametrised coordinate and color widths;
- a per-line dash pattern;
- clipping against the screen bounds, so off-screen pixels are never emitted.

---
 rtl/line_raster_engine.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/line_raster_engine.sv
// line_raster_engine
//   Accepts one line op (two endpoints, color, dash pattern) and walks it with
//   Bresenham's algorithm, offering one {x, y, color} pixel per cycle.
//   Pixels masked by the dash pattern or lying off-screen cost one cycle each
//   and are never offered downstream.
//
// Ports
//   clk, rst_                      clock, synchronous active-high reset
//   in_x1/in_y1/in_x2/in_y2        line endpoints (unsigned, inclusive)
//   in_color, in_pattern           line color, dash mask (bit i gates pixel i)
//   in_rts / in_rtr                op handshake (in_rtr = idle, not in reset)
//   out_x/out_y/out_color          pixel being offered
//   out_rts / out_rtr              pixel handshake
//   busy                           line in progress
//
// Handshake rule (both sides): a transfer happens on a rising edge where rts
// and rtr are both high. While out_rts is high and out_rtr low, out_x, out_y
// and out_color hold, and out_rts only drops after a transfer or on reset.
module line_raster_engine #(
  parameter int COORD_W   = 10,
  parameter int COLOR_W   = 12,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int PATTERN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic [COORD_W-1:0]   in_x1,
  input  logic [COORD_W-1:0]   in_y1,
  input  logic [COORD_W-1:0]   in_x2,
  input  logic [COORD_W-1:0]   in_y2,
  input  logic [COLOR_W-1:0]   in_color,
  input  logic [PATTERN_W-1:0] in_pattern,
  input  logic                 in_rts,
  output logic                 in_rtr,
  output logic [COORD_W-1:0]   out_x,
  output logic [COORD_W-1:0]   out_y,
  output logic [COLOR_W-1:0]   out_color,
  output logic                 out_rts,
  input  logic                 out_rtr,
  output logic                 busy
);

  localparam int ERR_W = COORD_W + 2;
  localparam int IDX_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
  localparam logic [COORD_W:0]   SCR_W    = SCREEN_W[COORD_W:0];
  localparam logic [COORD_W:0]   SCR_H    = SCREEN_H[COORD_W:0];
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(PATTERN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    STEP  = 2'd2
  } state_t;

  state_t                   state;
  logic [COORD_W-1:0]       x1_q, y1_q, x2_q, y2_q;
  logic [COLOR_W-1:0]       color_q;
  logic [PATTERN_W-1:0]     pattern_q;
  logic [COORD_W-1:0]       dx;
  logic signed [ERR_W-1:0]  dy;
  logic signed [ERR_W-1:0]  err;
  logic                     sx_neg, sy_neg;
  logic [COORD_W-1:0]       cur_x, cur_y;
  logic [IDX_W-1:0]         idx;

  // Setup-time values derived from the latched endpoints.
  logic [COORD_W-1:0]       setup_dx, setup_ady;
  logic signed [ERR_W-1:0]  setup_dy, setup_err;

  // Step-time decisions.
  logic                     emittable, advance, at_end;
  logic signed [ERR_W:0]    e2, dx_ext, dy_ext;
  logic                     step_x, step_y;
  logic signed [ERR_W-1:0]  err_next;

  always_comb begin
    setup_dx  = (x2_q >= x1_q) ? (x2_q - x1_q) : (x1_q - x2_q);
    setup_ady = (y2_q >= y1_q) ? (y2_q - y1_q) : (y1_q - y2_q);
    setup_dy  = $signed(ERR_W'(0) - {2'b00, setup_ady});
    setup_err = $signed({2'b00, setup_dx}) + setup_dy;
  end

  always_comb begin
    emittable = pattern_q[idx] &&
                ({1'b0, cur_x} < SCR_W) && ({1'b0, cur_y} < SCR_H);
    // Suppressed pixels advance unconditionally; shown ones wait for out_rtr.
    advance   = (state == STEP) && (!emittable || out_rtr);
    at_end    = (cur_x == x2_q) && (cur_y == y2_q);

    // Both axis decisions use the pre-step e2 and may fire together.
    e2       = $signed({err, 1'b0});
    dx_ext   = $signed({3'b000, dx});
    dy_ext   = {dy[ERR_W-1], dy};
    step_x   = (e2 >= dy_ext);
    step_y   = (e2 <= dx_ext);
    err_next = err;
    if (step_x) err_next = err_next + dy;
    if (step_y) err_next = err_next + $signed({2'b00, dx});
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state     <= IDLE;
      x1_q      <= '0;
      y1_q      <= '0;
      x2_q      <= '0;
      y2_q      <= '0;
      color_q   <= '0;
      pattern_q <= '0;
      dx        <= '0;
      dy        <= '0;
      err       <= '0;
      sx_neg    <= 1'b0;
      sy_neg    <= 1'b0;
      cur_x     <= '0;
      cur_y     <= '0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_rts) begin
            x1_q      <= in_x1;
            y1_q      <= in_y1;
            x2_q      <= in_x2;
            y2_q      <= in_y2;
            color_q   <= in_color;
            pattern_q <= in_pattern;
            state     <= SETUP;
          end
        end
        SETUP: begin
          dx     <= setup_dx;
          dy     <= setup_dy;
          err    <= setup_err;
          sx_neg <= (x2_q < x1_q);
          sy_neg <= (y2_q < y1_q);
          cur_x  <= x1_q;
          cur_y  <= y1_q;
          idx    <= '0;
          state  <= STEP;
        end
        STEP: begin
          if (advance) begin
            if (at_end) begin
              state <= IDLE;
            end else begin
              idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
              err <= err_next;
              if (step_x) cur_x <= sx_neg ? cur_x - 1'b1 : cur_x + 1'b1;
              if (step_y) cur_y <= sy_neg ? cur_y - 1'b1 : cur_y + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_rtr    = (state == IDLE) && !rst_;
  assign busy      = (state != IDLE);
  assign out_rts   = (state == STEP) && emittable;
  assign out_x     = cur_x;
  assign out_y     = cur_y;
  assign out_color = color_q;

endmodule
